// File: rtl/fetch_sequencer_pkg.sv
// Shared constants for the fetch sequencer and the decode-ROM bench:
// default widths, phase encodings and rom_addr field positions.
package fetch_sequencer_pkg;

  localparam int unsigned PC_W_DEFAULT = 12;
  localparam int unsigned OP_W_DEFAULT = 4;
  localparam int unsigned OPERAND_W    = 4;
  localparam int unsigned PROG_W       = 8;

  // Phase encodings double as the two FSM states
  localparam logic PH_FETCH   = 1'b0;
  localparam logic PH_EXECUTE = 1'b1;

  // rom_addr = {opcode, C, Z, phase}
  localparam int unsigned ROM_ADDR_W    = OP_W_DEFAULT + 3;
  localparam int unsigned ROM_PHASE_BIT = 0;
  localparam int unsigned ROM_Z_BIT     = 1;
  localparam int unsigned ROM_C_BIT     = 2;
  localparam int unsigned ROM_OP_LSB    = 3;
  localparam int unsigned ROM_OP_MSB    = ROM_OP_LSB + OP_W_DEFAULT - 1;

  function automatic logic [ROM_ADDR_W-1:0] make_rom_addr(
    input logic [OP_W_DEFAULT-1:0] opcode,
    input logic                    c,
    input logic                    z,
    input logic                    ph
  );
    logic [ROM_ADDR_W-1:0] a;
    a                = '0;
    a[ROM_OP_MSB:ROM_OP_LSB] = opcode;
    a[ROM_C_BIT]     = c;
    a[ROM_Z_BIT]     = z;
    a[ROM_PHASE_BIT] = ph;
    return a;
  endfunction

endpackage

// File: rtl/fetch_sequencer_program_counter.sv
// Program counter: load has priority over increment, increment wraps silently.
module program_counter
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  input  logic            load_i,
  input  logic            inc_i,
  input  logic [PC_W-1:0] ld_addr_i,
  output logic [PC_W-1:0] pc_o
);

  logic [PC_W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (en_i) begin
      if (load_i)     pc_d = ld_addr_i;
      else if (inc_i) pc_d = pc_q + PC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= '0;
    else     pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Two-phase FETCH/EXECUTE sequencer: holds IR and flags, steps the PC and
// forms the decode-ROM address from registered state.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEFAULT,
  parameter int unsigned OP_W = OP_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [PROG_W-1:0]     prog_byte,
  input  logic                  incpc,
  input  logic                  loadpc,
  input  logic [PC_W-1:0]       ld_addr,
  input  logic                  loadflags,
  input  logic                  carry_in,
  input  logic                  zero_in,
  output logic [PC_W-1:0]       pc,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  output logic [OPERAND_W-1:0]  operand,
  output logic                  phase
);

  logic                 phase_q, phase_d;
  logic [OP_W-1:0]      opcode_q, opcode_d;
  logic [OPERAND_W-1:0] operand_q, operand_d;
  logic                 c_q, c_d;
  logic                 z_q, z_d;

  program_counter #(.PC_W(PC_W)) u_pc (
    .clk       (clk),
    .rst       (reset),
    .en_i      (enable),
    .load_i    (loadpc),
    .inc_i     (incpc),
    .ld_addr_i (ld_addr),
    .pc_o      (pc)
  );

  // Next-state: IR loads only in FETCH, flags only in EXECUTE
  always_comb begin
    phase_d   = phase_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    c_d       = c_q;
    z_d       = z_q;
    if (enable) begin
      case (phase_q)
        PH_FETCH: begin
          phase_d   = PH_EXECUTE;
          opcode_d  = prog_byte[OPERAND_W +: OP_W];
          operand_d = prog_byte[OPERAND_W-1:0];
        end
        default: begin
          phase_d = PH_FETCH;
          if (loadflags) begin
            c_d = carry_in;
            z_d = zero_in;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q   <= PH_FETCH;
      opcode_q  <= '0;
      operand_q <= '0;
      c_q       <= 1'b0;
      z_q       <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      c_q       <= c_d;
      z_q       <= z_d;
    end
  end

  assign rom_addr = ROM_ADDR_W'({opcode_q, c_q, z_q, phase_q});
  assign operand  = operand_q;
  assign phase    = phase_q;

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 12, meaning program-counter width.
REQ-002 SHALL have parameter OP_W, default 4, meaning opcode field width (prog_byte[7:4]).
REQ-003 SHALL have clk  input  1  single system clock, all state updates on rising edge.
REQ-004 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have enable  input  1  1 = advance; 0 = freeze all state.
REQ-006 SHALL have prog_byte  input  8  program memory data at address pc, {opcode[7:4], operand[3:0]}.
REQ-007 SHALL have incpc  input  1  control-word bit, increment PC.
REQ-008 SHALL have loadpc  input  1  control-word bit, load PC from ld_addr.
REQ-009 SHALL have ld_addr  input  PC_W  jump target.
REQ-010 SHALL have loadflags  input  1  control-word bit, capture carry_in/zero_in.
REQ-011 SHALL have carry_in, zero_in  input  1 each  ALU flags.
REQ-012 SHALL have pc  output  PC_W  program-memory address.
REQ-013 SHALL have rom_addr  output  7  decode-ROM address {opcode[3:0], C, Z, phase}.
REQ-014 SHALL have operand  output  4  registered operand nibble.
REQ-015 SHALL have phase  output  1  0 = FETCH, 1 = EXECUTE.

Function
REQ-016 SHALL implement two-state FSM FETCH(0) -> EXECUTE(1) -> FETCH on every enabled clock; no other states.
REQ-017 SHALL, on enabled edge in FETCH, load instruction register {opcode, operand} from prog_byte; IR SHALL NOT load in EXECUTE.
REQ-018 SHALL, on enabled edge with loadflags=1 in EXECUTE, load C<=carry_in, Z<=zero_in; loadflags in FETCH SHALL be ignored.
REQ-019 SHALL update PC on enabled edge in either phase: loadpc=1 -> ld_addr; else incpc=1 -> pc+1; else hold.
REQ-020 SHALL give loadpc priority when loadpc and incpc both 1.
REQ-021 SHALL wrap pc from 2^PC_W-1 to 0 on increment, no flag, no stall.
REQ-022 SHALL drive rom_addr combinationally from registers: {IR opcode, C, Z, phase}; rom_addr[0]=0 in FETCH regardless of opcode/flags.
REQ-023 SHALL make new rom_addr visible in the cycle after the edge that loaded IR/flags/phase (latency 1 clock).
REQ-024 SHALL, with enable=0, hold pc, IR, C, Z and phase unchanged and ignore incpc/loadpc/loadflags.
REQ-025 SHALL drive operand directly from IR[3:0].

Reset
REQ-026 SHALL, on reset assertion, immediately force pc=0, IR=0, C=0, Z=0, phase=FETCH, hence rom_addr=7'b0000000, operand=0.
REQ-027 SHALL, on reset asserted mid-EXECUTE, abandon the instruction; first enabled edge after deassertion is a FETCH at pc=0.
REQ-028 SHALL give reset priority over enable and all control inputs.

Structure
REQ-029 SHALL place PC_W default, OP_W, phase encodings (FETCH=0, EXECUTE=1) and the rom_addr field positions in a shared package used also by the decode-ROM bench.
REQ-030 SHALL instantiate one sub-module program_counter (load/increment/hold, wrap, async reset); FSM, IR and flags stay in fetch_sequencer.

Verification
REQ-031 SHALL cover reset: assert reset mid-EXECUTE with pc=0x025 -> pc=0, phase=0, rom_addr=0000000 without a clock edge.
REQ-032 SHALL cover fetch/decode: prog_byte=0x3A, incpc=1 in FETCH -> next cycle phase=1, rom_addr={0011,C,Z,1}, operand=0xA, pc+1.
REQ-033 SHALL cover flags: EXECUTE with loadflags=1, carry_in=1, zero_in=0 -> next EXECUTE rom_addr[2:1]=10; loadflags=1 in FETCH -> flags unchanged.
REQ-034 SHALL cover jump priority: loadpc=1, incpc=1, ld_addr=0x123 -> pc=0x123.
REQ-035 SHALL cover wrap: pc=0xFFF, incpc=1 -> pc=0x000.
REQ-036 SHALL cover freeze: enable=0 for 5 cycles with toggling controls -> pc, phase, rom_addr, operand constant; resumes in same phase.
